// File: rtl/box_animator.sv
// Bouncing-box animator: draws a BOX_W x BOX_H box, waits DELAY*FRAMES cycles,
// erases it, moves it one pixel diagonally (reflecting off the screen edges) and repeats.
`timescale 1ns/1ps
module box_animator #(
  parameter int          SCREEN_W = 160,
  parameter int          SCREEN_H = 120,
  parameter int          BOX_W    = 4,
  parameter int          BOX_H    = 4,
  parameter int          X0       = 0,
  parameter int          Y0       = 60,
  parameter int          DELAY    = 833334,
  parameter int          FRAMES   = 15,
  parameter logic [2:0]  BG_COLOR = 3'b000
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        go,
  input  logic                        pause,
  input  logic                        stop,
  input  logic [2:0]                  color_in,
  output logic [$clog2(SCREEN_W)-1:0] x,
  output logic [$clog2(SCREEN_H)-1:0] y,
  output logic [2:0]                  color,
  output logic                        plot,
  output logic                        busy
);

  localparam int XW = $clog2(SCREEN_W);
  localparam int YW = $clog2(SCREEN_H);
  localparam int DW = (DELAY  > 1) ? $clog2(DELAY)  : 1;
  localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;

  localparam logic [XW-1:0] X_MAX   = XW'(SCREEN_W - BOX_W);
  localparam logic [YW-1:0] Y_MAX   = YW'(SCREEN_H - BOX_H);
  localparam logic [XW-1:0] OX_LAST = XW'(BOX_W - 1);
  localparam logic [YW-1:0] OY_LAST = YW'(BOX_H - 1);
  localparam logic [DW-1:0] FC_LAST = DW'(DELAY - 1);
  localparam logic [FW-1:0] TC_LAST = FW'(FRAMES - 1);

  typedef enum logic [2:0] {S_IDLE, S_DRAW, S_WAIT, S_ERASE, S_MOVE} state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] pos_x_q, pos_x_d, ox_q, ox_d, x_q, x_d;
  logic [YW-1:0] pos_y_q, pos_y_d, oy_q, oy_d, y_q, y_d;
  logic          dxn_q, dxn_d, dyn_q, dyn_d;   // 1 = moving in the negative direction
  logic [DW-1:0] fc_q, fc_d;
  logic [FW-1:0] tc_q, tc_d;
  logic [2:0]    col_q, col_d, color_q, color_d;
  logic          pend_q, pend_d, plot_q, plot_d, busy_q, busy_d;
  logic          last_px;

  always_comb begin
    state_d = state_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    dxn_d   = dxn_q;
    dyn_d   = dyn_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    fc_d    = fc_q;
    tc_d    = tc_q;
    col_d   = col_q;
    pend_d  = pend_q;
    x_d     = x_q;
    y_d     = y_q;
    color_d = color_q;
    plot_d  = 1'b0;
    last_px = 1'b0;

    if (state_q != S_IDLE && stop) pend_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d = S_DRAW;
          pos_x_d = XW'(X0);
          pos_y_d = YW'(Y0);
          dxn_d   = 1'b0;
          dyn_d   = 1'b0;
          ox_d    = '0;
          oy_d    = '0;
          col_d   = color_in;
          pend_d  = 1'b0;
        end
      end
      S_DRAW, S_ERASE: begin
        // Output registers take the current scan position; counters advance row-major.
        plot_d  = 1'b1;
        x_d     = pos_x_q + ox_q;
        y_d     = pos_y_q + oy_q;
        color_d = (state_q == S_DRAW) ? col_q : BG_COLOR;
        if (ox_q == OX_LAST) begin
          ox_d = '0;
          if (oy_q == OY_LAST) begin
            oy_d    = '0;
            last_px = 1'b1;
          end else begin
            oy_d = oy_q + YW'(1);
          end
        end else begin
          ox_d = ox_q + XW'(1);
        end
        if (last_px) begin
          if (state_q == S_DRAW) begin
            state_d = S_WAIT;
            fc_d    = '0;
            tc_d    = '0;
          end else if (pend_q || stop) begin
            state_d = S_IDLE;
            pend_d  = 1'b0;
          end else begin
            state_d = S_MOVE;
          end
        end
      end
      S_WAIT: begin
        if (!pause) begin
          if (fc_q == FC_LAST) begin
            fc_d = '0;
            if (tc_q == TC_LAST) state_d = S_ERASE;
            else                 tc_d = tc_q + FW'(1);
          end else begin
            fc_d = fc_q + DW'(1);
          end
        end
      end
      S_MOVE: begin
        // Reflection flips direction and steps back inward in the same move.
        if (!dxn_q) begin
          if (pos_x_q == X_MAX) begin dxn_d = 1'b1; pos_x_d = pos_x_q - XW'(1); end
          else                         pos_x_d = pos_x_q + XW'(1);
        end else begin
          if (pos_x_q == '0) begin dxn_d = 1'b0; pos_x_d = pos_x_q + XW'(1); end
          else                    pos_x_d = pos_x_q - XW'(1);
        end
        if (!dyn_q) begin
          if (pos_y_q == Y_MAX) begin dyn_d = 1'b1; pos_y_d = pos_y_q - YW'(1); end
          else                         pos_y_d = pos_y_q + YW'(1);
        end else begin
          if (pos_y_q == '0) begin dyn_d = 1'b0; pos_y_d = pos_y_q + YW'(1); end
          else                    pos_y_d = pos_y_q - YW'(1);
        end
        state_d = S_DRAW;
        col_d   = color_in;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      pos_x_q <= XW'(X0);
      pos_y_q <= YW'(Y0);
      dxn_q   <= 1'b0;
      dyn_q   <= 1'b0;
      ox_q    <= '0;
      oy_q    <= '0;
      fc_q    <= '0;
      tc_q    <= '0;
      col_q   <= '0;
      pend_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
      plot_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      dxn_q   <= dxn_d;
      dyn_q   <= dyn_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      fc_q    <= fc_d;
      tc_q    <= tc_d;
      col_q   <= col_d;
      pend_q  <= pend_d;
      x_q     <= x_d;
      y_q     <= y_d;
      color_q <= color_d;
      plot_q  <= plot_d;
      busy_q  <= busy_d;
    end
  end

  assign x     = x_q;
  assign y     = y_q;
  assign color = color_q;
  assign plot  = plot_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_box_animator.sv
// Directed bench for box_animator on an 8x6 screen with a 2x2 box, DELAY=4, FRAMES=2.
`timescale 1ns/1ps
module tb_box_animator;

  logic       clock = 1'b0;
  logic       reset, go, pause, stop;
  logic [2:0] color_in;
  logic [2:0] x_a, y_a, color_a, x_c, y_c, color_c;
  logic       plot_a, busy_a, plot_c, busy_c;
  logic       sel;
  logic [2:0] m_x, m_y, m_color;
  logic       m_plot, m_busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  box_animator #(.SCREEN_W(8), .SCREEN_H(6), .BOX_W(2), .BOX_H(2), .X0(0), .Y0(0),
                 .DELAY(4), .FRAMES(2), .BG_COLOR(3'b000)) u_dut_a (
    .clock(clock), .reset(reset), .go(go), .pause(pause), .stop(stop),
    .color_in(color_in), .x(x_a), .y(y_a), .color(color_a), .plot(plot_a), .busy(busy_a));

  // Second instance starts at x=2 so its path reaches the (6,4) corner.
  box_animator #(.SCREEN_W(8), .SCREEN_H(6), .BOX_W(2), .BOX_H(2), .X0(2), .Y0(0),
                 .DELAY(4), .FRAMES(2), .BG_COLOR(3'b000)) u_dut_c (
    .clock(clock), .reset(reset), .go(go), .pause(pause), .stop(stop),
    .color_in(color_in), .x(x_c), .y(y_c), .color(color_c), .plot(plot_c), .busy(busy_c));

  assign m_x     = sel ? x_c     : x_a;
  assign m_y     = sel ? y_c     : y_a;
  assign m_color = sel ? color_c : color_a;
  assign m_plot  = sel ? plot_c  : plot_a;
  assign m_busy  = sel ? busy_c  : busy_a;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Counts low-plot cycles until plot rises; a timeout counts as a failure.
  task automatic wait_plot(output int gap);
    gap = 0;
    while (!m_plot && gap < 200) begin
      gap++;
      @(negedge clock);
    end
    if (!m_plot) check("plot_timeout", 0, 1);
  endtask

  // Called with the first pixel of a pass visible; checks all four and steps past them.
  task automatic check_box(input int px, input int py, input int col, input string tag,
                           input bit do_stop);
    int got, exp;
    for (int oy = 0; oy < 2; oy++) begin
      for (int ox = 0; ox < 2; ox++) begin
        if (do_stop && ox == 0 && oy == 0) stop = 1'b1;
        got = {22'd0, m_plot, m_x, m_y, m_color};
        exp = (1 << 9) | ((px + ox) << 6) | ((py + oy) << 3) | col;
        check($sformatf("%s_px%0d", tag, oy * 2 + ox), got, exp);
        @(negedge clock);
        stop = 1'b0;
      end
    end
  endtask

  task automatic pulse_go(input logic [2:0] col, input bit with_stop);
    color_in = col;
    go       = 1'b1;
    stop     = with_stop;
    @(negedge clock);
    go   = 1'b0;
    stop = 1'b0;
  endtask

  // Erase of the previous box followed by the draw at the next position.
  task automatic step(input int pxp, input int pyp, input int px, input int py,
                      input int col, input string tag);
    int g;
    wait_plot(g);
    check({tag, "_wait"}, g, 8);
    check_box(pxp, pyp, 0, {tag, "_erase"}, 1'b0);
    wait_plot(g);
    check({tag, "_move"}, g, 1);
    check_box(px, py, col, {tag, "_draw"}, 1'b0);
  endtask

  int ax[6] = '{2, 3, 4, 5, 6, 5};
  int ay[6] = '{2, 3, 4, 3, 2, 1};
  int cx[5] = '{3, 4, 5, 6, 5};
  int cy[5] = '{1, 2, 3, 4, 3};

  initial begin
    int g, gp, nplots;
    reset = 1'b1; go = 1'b0; pause = 1'b0; stop = 1'b0; color_in = 3'b000; sel = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_plot", m_plot, 0);
    check("rst_busy", m_busy, 0);
    check("rst_x", m_x, 0);
    check("rst_y", m_y, 0);
    check("rst_color", m_color, 0);
    reset = 1'b0;
    @(negedge clock);

    // First draw, wait, erase, move, draw; colour changes mid-draw must not leak.
    pulse_go(3'b101, 1'b0);
    check("go_busy", m_busy, 1);
    wait_plot(g);
    check("go_latency", g, 1);
    check_box(0, 0, 5, "draw0", 1'b0);
    wait_plot(g);
    check("wait0", g, 8);
    check_box(0, 0, 0, "erase0", 1'b0);
    wait_plot(g);
    check("move0", g, 1);
    color_in = 3'b010;
    check_box(1, 1, 5, "draw1", 1'b0);
    for (int i = 0; i < 6; i++)
      step(i == 0 ? 1 : ax[i-1], i == 0 ? 1 : ay[i-1], ax[i], ay[i], 2,
           $sformatf("a%0d", i));

    // Pause for 20 cycles inside WAIT stretches the gap to 28.
    pause = 1'b1;
    gp = 0;
    repeat (20) begin
      if (!m_plot) gp++;
      @(negedge clock);
    end
    pause = 1'b0;
    wait_plot(g);
    check("pause_gap", gp + g, 28);
    check_box(5, 1, 0, "pause_erase", 1'b0);
    wait_plot(g);
    check("pause_move", g, 1);

    // Stop mid-draw: draw finishes, wait, erase, then idle with no plots.
    check_box(4, 0, 2, "stop_draw", 1'b1);
    wait_plot(g);
    check("stop_wait", g, 8);
    check_box(4, 0, 0, "stop_erase", 1'b0);
    check("stop_idle_busy", m_busy, 0);
    check("stop_idle_plot", m_plot, 0);
    nplots = 0;
    repeat (30) begin
      if (m_plot) nplots++;
      @(negedge clock);
    end
    check("stop_no_plots", nplots, 0);
    pulse_go(3'b011, 1'b0);
    wait_plot(g);
    check_box(0, 0, 3, "restart", 1'b0);
    wait_plot(g);
    check_box(0, 0, 0, "restart_erase", 1'b0);

    // Reset on the second pixel of a draw aborts immediately.
    wait_plot(g);
    check("rst_mid_move", g, 1);
    check("rst_mid_p1", m_plot, 1);
    @(negedge clock);
    check("rst_mid_p2", m_plot, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rst_mid_plot", m_plot, 0);
    check("rst_mid_busy", m_busy, 0);

    // go together with stop in IDLE: go wins, no pending stop.
    pulse_go(3'b110, 1'b1);
    wait_plot(g);
    check_box(0, 0, 6, "gs_draw", 1'b0);
    step(0, 0, 1, 1, 6, "gs");

    // Corner reflection on the second instance.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    sel   = 1'b1;
    pulse_go(3'b001, 1'b0);
    wait_plot(g);
    check_box(2, 0, 1, "c_draw0", 1'b0);
    for (int i = 0; i < 5; i++)
      step(i == 0 ? 2 : cx[i-1], i == 0 ? 0 : cy[i-1], cx[i], cy[i], 1,
           $sformatf("c%0d", i));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
